// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and byte-merge helper for the data memory arbiter
package dmem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Byte lane i comes from new_w where be[i] is set, otherwise from old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory pins of the data memory arbiter
interface dmem_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_be;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_be;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    input  mem_rd,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_a, mem_wd
  );

  // Requester / memory side.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    output mem_rd,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter holding the last-granted port
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic [1:0] w_gnt;

  // On a conflict the port that was not granted last time wins.
  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) w_gnt = r_last ? 2'b01 : 2'b10;
      else                w_gnt = i_req;
    end
  end

  assign o_gnt = w_gnt;

  // Remember the granted port; reset to 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last <= 1'b1;
    else if (|w_gnt) r_last <= w_gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data memory arbiter with sub-word read-modify-write
import dmem_pkg::*;

module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  w_gnt;
  logic        w_en, w_granted;
  logic        w_we, w_in_range, w_full, w_partial, w_rmw_start;
  logic [31:0] w_addr, w_wdata, w_word_addr;
  logic [3:0]  w_be;
  logic        w_mem_we;
  logic [31:0] w_mem_a, w_mem_wd;
  logic [31:0] r_addr, r_merged;
  logic        r_p0_rvalid, r_p1_rvalid;
  logic [31:0] r_p0_rdata, r_p1_rdata;

  // Grants are only made in IDLE and never while reset is held.
  assign w_en = (r_state == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({bus.p1_req, bus.p0_req}),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  // Select the granted port's request fields and classify the access.
  always_comb begin
    w_granted   = |w_gnt;
    w_we        = w_gnt[1] ? bus.p1_we    : bus.p0_we;
    w_addr      = w_gnt[1] ? bus.p1_addr  : bus.p0_addr;
    w_wdata     = w_gnt[1] ? bus.p1_wdata : bus.p0_wdata;
    w_be        = w_gnt[1] ? bus.p1_be    : bus.p0_be;
    w_word_addr = w_addr & 32'hFFFF_FFFC;
    w_in_range  = (w_addr >> 2) < 32'(DEPTH_WORDS);
    w_full      = (w_be == BE_FULL);
    w_partial   = (w_be != 4'h0) && !w_full;
    w_rmw_start = w_granted && w_we && w_partial && w_in_range;
  end

  // Next state and memory pin drive; the RMW write drops as soon as reset rises.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_a     = 32'h0;
    w_mem_wd    = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_granted) begin
          w_mem_a = w_word_addr;
          if (w_we && w_in_range && w_full) begin
            w_mem_we = 1'b1;
            w_mem_wd = w_wdata;
          end
          if (w_rmw_start) w_state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        w_mem_we    = !rst;
        w_mem_a     = r_addr;
        w_mem_wd    = r_merged;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture the target address and merged word when a partial store is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_merged <= 32'h0;
    end else if (w_rmw_start) begin
      r_addr   <= w_word_addr;
      r_merged <= merge_bytes(bus.mem_rd, w_wdata, w_be);
    end
  end

  // Per-port load responses; out-of-range loads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= 32'h0;
      r_p1_rdata  <= 32'h0;
    end else begin
      r_p0_rvalid <= w_gnt[0] && !w_we;
      r_p1_rvalid <= w_gnt[1] && !w_we;
      if (w_gnt[0] && !w_we) r_p0_rdata <= w_in_range ? bus.mem_rd : 32'h0;
      if (w_gnt[1] && !w_we) r_p1_rdata <= w_in_range ? bus.mem_rd : 32'h0;
    end
  end

  assign bus.p0_gnt    = w_gnt[0];
  assign bus.p1_gnt    = w_gnt[1];
  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p1_rvalid = r_p1_rvalid;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_a     = w_mem_a;
  assign bus.mem_wd    = w_mem_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] mem [0:63];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported memory model: combinational read, write on rising edge.
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[7:2]] = bus.mem_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_ports();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0; bus.p0_be = 4'h0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0; bus.p1_be = 4'h0;
  endtask

  task automatic p0_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd; bus.p0_be = be;
  endtask

  task automatic p1_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd; bus.p1_be = be;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    mem[3] = 32'h11223344;
    idle_ports();
    rst = 1'b1;

    // Reset values, with a live request that must not be granted.
    #2;
    p0_drive(1'b0, 32'h8, 32'h0, 4'hF);
    #1;
    check_eq("rst_p0_gnt",    32'(bus.p0_gnt), 32'h0);
    check_eq("rst_mem_we",    32'(bus.mem_we), 32'h0);
    check_eq("rst_mem_a",     bus.mem_a, 32'h0);
    check_eq("rst_mem_wd",    bus.mem_wd, 32'h0);
    check_eq("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
    check_eq("rst_p0_rdata",  bus.p0_rdata, 32'h0);
    check_eq("rst_p1_rdata",  bus.p1_rdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    idle_ports();

    // Conflicting loads for four cycles: p0, p1, p0, p1.
    for (int k = 0; k < 4; k++) begin
      step();
      p0_drive(1'b0, 32'h8, 32'h0, 4'hF);
      p1_drive(1'b0, 32'hC, 32'h0, 4'hF);
      #1;
      check_eq($sformatf("rr_p0_gnt_%0d", k), 32'(bus.p0_gnt), 32'((k % 2) == 0));
      check_eq($sformatf("rr_p1_gnt_%0d", k), 32'(bus.p1_gnt), 32'((k % 2) == 1));
      if (k > 0) begin
        check_eq($sformatf("rr_p0_rvalid_%0d", k), 32'(bus.p0_rvalid), 32'(((k - 1) % 2) == 0));
        check_eq($sformatf("rr_p1_rvalid_%0d", k), 32'(bus.p1_rvalid), 32'(((k - 1) % 2) == 1));
      end
    end
    step();
    idle_ports();
    #1;
    check_eq("rr_last_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
    check_eq("rr_last_p1_rdata",  bus.p1_rdata, 32'h11223344);
    check_eq("rr_p0_rdata_held",  bus.p0_rdata, 32'hDEADBEEF);

    // Single load on p0.
    step();
    p0_drive(1'b0, 32'h8, 32'h0, 4'hF);
    #1;
    check_eq("ld_p0_gnt",  32'(bus.p0_gnt), 32'h1);
    check_eq("ld_p1_gnt",  32'(bus.p1_gnt), 32'h0);
    check_eq("ld_mem_a",   bus.mem_a, 32'h8);
    check_eq("ld_mem_we",  32'(bus.mem_we), 32'h0);
    step();
    idle_ports();
    #1;
    check_eq("ld_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
    check_eq("ld_p0_rdata",  bus.p0_rdata, 32'hDEADBEEF);
    check_eq("ld_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
    step();
    check_eq("ld_p0_rvalid_pulse", 32'(bus.p0_rvalid), 32'h0);

    // Partial store on p1 to word 3, blocked load on p0 during the write-back.
    p1_drive(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101);
    #1;
    check_eq("rmw_n_gnt",   32'(bus.p1_gnt), 32'h1);
    check_eq("rmw_n_we",    32'(bus.mem_we), 32'h0);
    check_eq("rmw_n_a",     bus.mem_a, 32'hC);
    step();
    idle_ports();
    p0_drive(1'b0, 32'hC, 32'h0, 4'hF);
    #1;
    check_eq("rmw_n1_we",     32'(bus.mem_we), 32'h1);
    check_eq("rmw_n1_wd",     bus.mem_wd, 32'h11BB33DD);
    check_eq("rmw_n1_a",      bus.mem_a, 32'hC);
    check_eq("rmw_n1_p0_gnt", 32'(bus.p0_gnt), 32'h0);
    check_eq("rmw_n1_p1_gnt", 32'(bus.p1_gnt), 32'h0);
    step();
    check_eq("rmw_n2_p0_gnt", 32'(bus.p0_gnt), 32'h1);
    step();
    idle_ports();
    #1;
    check_eq("rmw_rd_rvalid", 32'(bus.p0_rvalid), 32'h1);
    check_eq("rmw_rd_rdata",  bus.p0_rdata, 32'h11BB33DD);

    // Full-word store then load back.
    p0_drive(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    #1;
    check_eq("fs_gnt",   32'(bus.p0_gnt), 32'h1);
    check_eq("fs_we",    32'(bus.mem_we), 32'h1);
    check_eq("fs_wd",    bus.mem_wd, 32'hCAFEF00D);
    check_eq("fs_a",     bus.mem_a, 32'h10);
    step();
    p0_drive(1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    check_eq("fs_ld_gnt", 32'(bus.p0_gnt), 32'h1);
    step();
    idle_ports();
    #1;
    check_eq("fs_ld_rvalid", 32'(bus.p0_rvalid), 32'h1);
    check_eq("fs_ld_rdata",  bus.p0_rdata, 32'hCAFEF00D);

    // Out-of-range load and store.
    p0_drive(1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    check_eq("oor_ld_gnt", 32'(bus.p0_gnt), 32'h1);
    step();
    idle_ports();
    p1_drive(1'b1, 32'h100, 32'h12345678, 4'hF);
    #1;
    check_eq("oor_ld_rvalid", 32'(bus.p0_rvalid), 32'h1);
    check_eq("oor_ld_rdata",  bus.p0_rdata, 32'h0);
    check_eq("oor_st_gnt",    32'(bus.p1_gnt), 32'h1);
    check_eq("oor_st_we",     32'(bus.mem_we), 32'h0);
    step();

    // Store with no byte enables: granted, no write, no blocking.
    idle_ports();
    p1_drive(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0);
    #1;
    check_eq("be0_gnt", 32'(bus.p1_gnt), 32'h1);
    check_eq("be0_we",  32'(bus.mem_we), 32'h0);
    step();
    idle_ports();
    p0_drive(1'b0, 32'h14, 32'h0, 4'hF);
    #1;
    check_eq("be0_next_gnt", 32'(bus.p0_gnt), 32'h1);
    step();
    idle_ports();
    #1;
    check_eq("be0_rdata", bus.p0_rdata, 32'h0);

    // Reset during RMW_WR abandons the write.
    p1_drive(1'b1, 32'h8, 32'h000000AA, 4'b0001);
    #1;
    check_eq("rstrmw_gnt", 32'(bus.p1_gnt), 32'h1);
    step();
    idle_ports();
    #1;
    check_eq("rstrmw_we_pre", 32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rstrmw_we_drop", 32'(bus.mem_we), 32'h0);
    step();
    check_eq("rstrmw_mem_kept", mem[2], 32'hDEADBEEF);
    rst = 1'b0;
    p0_drive(1'b0, 32'h8, 32'h0, 4'hF);
    p1_drive(1'b0, 32'hC, 32'h0, 4'hF);
    #1;
    check_eq("rstrmw_p0_wins", 32'(bus.p0_gnt), 32'h1);
    check_eq("rstrmw_p1_loses", 32'(bus.p1_gnt), 32'h0);
    step();
    idle_ports();
    #1;
    check_eq("rstrmw_ld_rdata", bus.p0_rdata, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
